input_debounce: RTL and testbench

//  Conditions raw asynchronous board inputs (2 push-buttons + 4 DIP switches) ahead of the

---
 rtl/input_cond_pkg.sv | 25 ++
 rtl/debounce_bit.sv | 62 ++++++
 rtl/input_debounce.sv | 38 +++
 tb/tb_input_debounce.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/input_cond_pkg.sv
// Shared constants for the board input conditioning path: field positions of the
// push-buttons and DIP switches within the raw input vector, and default tuning.
package input_cond_pkg;

    localparam int DEFAULT_WIDTH         = 6;
    localparam int DEFAULT_SYNC_STAGES   = 2;
    // 20 ms at the 50 MHz fabric clock
    localparam int DEFAULT_STABLE_CYCLES = 1_000_000;

    // Field positions within raw_in / clean_out
    localparam int BTN_IDX   = 0;
    localparam int BTN_W     = 2;
    localparam int DIPSW_IDX = 2;
    localparam int DIPSW_W   = 4;

    // Buttons are active-low and idle high; DIP switches reset low
    localparam logic [DEFAULT_WIDTH-1:0] DEFAULT_RESET_VALUE = 6'b000011;

    // Packed view of the board inputs, matching the field positions above
    typedef struct packed {
        logic [DIPSW_W-1:0] dipsw;
        logic [BTN_W-1:0]   btn;
    } board_in_t;

endpackage

// File: rtl/debounce_bit.sv
// Single-bit input conditioner: synchroniser chain, stability-counter debounce
// and registered one-cycle rise/fall strobes aligned with the new clean level.
module debounce_bit #(
    parameter int   SYNC_STAGES   = 2,
    parameter int   STABLE_CYCLES = 8,
    parameter logic RESET_BIT     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic clean,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic [CNT_W-1:0]       cnt;
    logic                   settle;

    // Only the last synchroniser stage is observed; earlier stages carry no logic.
    assign synced = sync_q[SYNC_STAGES-1];

    // The synced level has differed from clean for long enough to be accepted.
    assign settle = (synced != clean) && (cnt == CNT_LAST);

    // Synchroniser shift chain, reset to the idle level so release produces no edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RESET_BIT}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    // Stability counter, clean level update and edge strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            clean <= RESET_BIT;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= settle & synced;
            fall <= settle & ~synced;
            // Any return to the clean level throws away the partial count, so
            // bounces shorter than the threshold never reach the output.
            if ((synced == clean) || settle) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            if (settle) begin
                clean <= synced;
            end
        end
    end

endmodule

// File: rtl/input_debounce.sv
// Debounces the raw push-button and DIP-switch pins feeding the HPS PIOs.
// One debounce_bit per input; the top only adds the any-change summary strobe.
module input_debounce
    import input_cond_pkg::*;
#(
    parameter int                 WIDTH         = DEFAULT_WIDTH,
    parameter int                 SYNC_STAGES   = DEFAULT_SYNC_STAGES,
    parameter int                 STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter logic [WIDTH-1:0]   RESET_VALUE   = DEFAULT_RESET_VALUE
) (
    input  logic             clk_clk,
    input  logic             reset_reset,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] clean_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             any_change
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .SYNC_STAGES  (SYNC_STAGES),
            .STABLE_CYCLES(STABLE_CYCLES),
            .RESET_BIT    (RESET_VALUE[i])
        ) u_bit (
            .clk  (clk_clk),
            .rst  (reset_reset),
            .raw  (raw_in[i]),
            .clean(clean_out[i]),
            .rise (rise_pulse[i]),
            .fall (fall_pulse[i])
        );
    end

    // Built from the registered strobes, so it is high in exactly the same cycle.
    assign any_change = |(rise_pulse | fall_pulse);

endmodule

// File: tb/tb_input_debounce.sv
// Scoreboard bench for input_debounce with an 8-cycle stability threshold.
// Stimulus pushes the expected strobe (cycle, rise, fall, clean) into a queue;
// a negedge monitor pops and compares whenever the DUT raises a strobe.
module tb_input_debounce;

    localparam int LAT = 10; // SYNC_STAGES (2) + STABLE_CYCLES (8)

    logic       clk_clk     = 1'b0;
    logic       reset_reset = 1'b1;
    logic [5:0] raw_in      = 6'h00;
    logic [5:0] clean_out;
    logic [5:0] rise_pulse;
    logic [5:0] fall_pulse;
    logic       any_change;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int         cyc;
        logic [5:0] rise;
        logic [5:0] fall;
        logic [5:0] clean;
    } exp_t;

    exp_t exp_q[$];
    logic [5:0] prev_clean = 6'h00;

    input_debounce #(
        .WIDTH        (6),
        .SYNC_STAGES  (2),
        .STABLE_CYCLES(8),
        .RESET_VALUE  (6'b000011)
    ) dut (
        .clk_clk    (clk_clk),
        .reset_reset(reset_reset),
        .raw_in     (raw_in),
        .clean_out  (clean_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .any_change (any_change)
    );

    always #5 clk_clk = ~clk_clk;

    always @(posedge clk_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Advance n active edges and land 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk_clk);
        #1;
    endtask

    // Expected strobe LAT edges after the input change made now.
    task automatic expect_evt(input logic [5:0] r, input logic [5:0] f, input logic [5:0] c);
        exp_t e;
        e.cyc   = cyc + LAT;
        e.rise  = r;
        e.fall  = f;
        e.clean = c;
        exp_q.push_back(e);
    endtask

    task automatic chk_idle(input string name, input logic [5:0] c);
        chk({name, "_clean"}, 32'(clean_out), 32'(c));
        chk({name, "_rise"}, 32'(rise_pulse), 32'h0);
        chk({name, "_fall"}, 32'(fall_pulse), 32'h0);
        chk({name, "_any"}, 32'(any_change), 32'h0);
    endtask

    // Monitor: compare every strobe against the scoreboard head.
    always @(negedge clk_clk) begin
        if (!reset_reset) begin
            chk("any_change_or", 32'(any_change), 32'(|(rise_pulse | fall_pulse)));
            if ((rise_pulse & fall_pulse) != 6'h00)
                chk("rise_fall_overlap", 32'(rise_pulse & fall_pulse), 32'h0);
            if ((rise_pulse | fall_pulse) != 6'h00) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", {20'h0, rise_pulse, fall_pulse}, 32'h0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("evt_cycle", 32'(cyc), 32'(e.cyc));
                    chk("evt_rise", 32'(rise_pulse), 32'(e.rise));
                    chk("evt_fall", 32'(fall_pulse), 32'(e.fall));
                    chk("evt_clean", 32'(clean_out), 32'(e.clean));
                end
            end else if (clean_out != prev_clean) begin
                chk("clean_change_without_pulse", 32'(clean_out), 32'(prev_clean));
            end
        end
        prev_clean <= clean_out;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // 1: reset held 3 cycles with all pins low
        step(1);
        chk_idle("reset_hold1", 6'h03);
        step(2);
        chk_idle("reset_hold3", 6'h03);
        reset_reset = 1'b0;
        expect_evt(6'h00, 6'h03, 6'h00);
        step(1);
        chk_idle("post_release1", 6'h03);
        step(1);
        chk_idle("post_release2", 6'h03);
        step(10);
        raw_in = 6'h03;
        expect_evt(6'h03, 6'h00, 6'h03);
        step(12);
        chk("idle_level", 32'(clean_out), 32'h03);

        // 2: clean press on button 0 and release
        raw_in = 6'h02;
        expect_evt(6'h00, 6'h01, 6'h02);
        step(9);
        chk("press_not_yet", 32'(clean_out), 32'h03);
        step(6);
        chk("press_level", 32'(clean_out), 32'h02);
        raw_in = 6'h03;
        expect_evt(6'h01, 6'h00, 6'h03);
        step(15);

        // 3: bounce on DIP 2 shorter than threshold
        raw_in = 6'h07;
        step(5);
        raw_in = 6'h03;
        step(50);
        chk("bounce_level", 32'(clean_out), 32'h03);

        // 4: threshold edge on DIP 3: 7 cycles rejected, 8 accepted
        raw_in = 6'h0B;
        step(7);
        raw_in = 6'h03;
        step(20);
        chk("thresh7_level", 32'(clean_out), 32'h03);
        raw_in = 6'h0B;
        expect_evt(6'h08, 6'h00, 6'h0B);
        step(8);
        raw_in = 6'h03;
        expect_evt(6'h00, 6'h08, 6'h03);
        step(15);
        chk("thresh8_back", 32'(clean_out), 32'h03);

        // 5: all DIP switches change on the same edge
        raw_in = 6'h3F;
        expect_evt(6'h3C, 6'h00, 6'h3F);
        step(12);
        chk("simul_level", 32'(clean_out), 32'h3F);
        raw_in = 6'h03;
        expect_evt(6'h00, 6'h3C, 6'h03);
        step(12);

        // 6: reset in the middle of a button 1 count
        raw_in = 6'h01;
        step(5);
        #2;
        reset_reset = 1'b1;
        #1;
        chk_idle("async_reset", 6'h03);
        step(2);
        reset_reset = 1'b0;
        expect_evt(6'h00, 6'h02, 6'h01);
        step(5);
        chk("midcount_no_early", 32'(clean_out), 32'h03);
        step(10);
        chk("midcount_level", 32'(clean_out), 32'h01);

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) step(1);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
